// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the SOF/LEN/payload/XOR-checksum frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_e;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;
    localparam int         MAX_LEN_DEF  = 16;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buffer.sv
// Payload store: one synchronous write port, one asynchronous read port.
module uart_frame_buffer
    import uart_frame_pkg::*;
#(
    parameter  int DEPTH = MAX_LEN_DEF,
    localparam int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SOF, LEN, payload, XOR checksum; drains payload over valid/ready.
// Define UART_FRAME_PARSER_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES idle cycles.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = MAX_LEN_DEF,
    parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_valid,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_data_ready,
    output logic       o_data_last,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int         AW        = idx_w(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] xor_q, xor_d;
    logic       valid_q, valid_d;
    logic       ok_q, ok_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;
    logic       we;
    logic       last;
    logic [7:0] rdata;

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int          GW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);
    logic [GW-1:0] gap_q, gap_d;
`else
    // TIMEOUT_CYCLES has no effect when the gap counter is not built
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // idx doubles as write index while filling and read index while draining
    assign last = valid_q && (idx_q == len_q - 8'd1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        xor_d   = xor_q;
        valid_d = valid_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_rx_data_valid && i_rx_data == SOF_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_rx_data_valid) begin
                    if (i_rx_data == 8'd0 || i_rx_data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = i_rx_data;
                        xor_d   = i_rx_data;
                        idx_d   = 8'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_rx_data_valid) begin
                    we    = 1'b1;
                    xor_d = xor_q ^ i_rx_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (i_rx_data_valid) begin
                    if (i_rx_data == xor_q) begin
                        ok_d    = 1'b1;
                        valid_d = 1'b1;
                        idx_d   = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                ovr_d = i_rx_data_valid;
                if (valid_q && i_data_ready) begin
                    if (last) begin
                        valid_d = 1'b0;
                        idx_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        gap_d = '0;
        if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK)
            && !i_rx_data_valid) begin
            if (gap_q == GAP_MAX) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            xor_q   <= 8'd0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            gap_q   <= gap_d;
`endif
        end
    end

    uart_frame_buffer #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (idx_q[AW-1:0]),
        .wdata (i_rx_data),
        .raddr (idx_q[AW-1:0]),
        .rdata (rdata)
    );

    assign o_data       = valid_q ? rdata : 8'h00;
    assign o_data_valid = valid_q;
    assign o_data_last  = last;
    assign o_frame_ok   = ok_q;
    assign o_frame_err  = err_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame table plus corner-case sequences.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_data_last;
    logic       o_frame_ok;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    uart_frame_parser #(
        .MAX_LEN        (16),
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .i_rx_data       (rx_data),
        .i_rx_data_valid (rx_valid),
        .o_data          (o_data),
        .o_data_valid    (o_data_valid),
        .i_data_ready    (ready),
        .o_data_last     (o_data_last),
        .o_frame_ok      (o_frame_ok),
        .o_frame_err     (o_frame_err),
        .o_overrun       (o_overrun),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        int                n;
        logic [0:19][7:0]  b;
        int                ok;
        int                err;
        int                pofs;
        int                np;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    int         n_ok, n_err, n_ovr;
    int         cyc = 0;
    logic [7:0] out_q[$];
    logic       last_q[$];
    int         cyc_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (resetn) begin
            if (o_frame_ok)  n_ok++;
            if (o_frame_err) n_err++;
            if (o_overrun)   n_ovr++;
            if (o_frame_ok || o_frame_err || o_overrun)
                check("pulse_excl", 32'(o_frame_ok) + 32'(o_frame_err)
                      + 32'(o_overrun), 32'd1);
            if (stall_prev) begin
                check("stall_valid", 32'(o_data_valid), 32'd1);
                check("stall_data", 32'(o_data), 32'(prev_data));
                check("stall_last", 32'(o_data_last), 32'(prev_last));
            end
            if (o_data_valid && ready) begin
                out_q.push_back(o_data);
                last_q.push_back(o_data_last);
                cyc_q.push_back(cyc);
            end
            stall_prev = o_data_valid && !ready;
            prev_data  = o_data;
            prev_last  = o_data_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic clear_mon();
        n_ok = 0;
        n_err = 0;
        n_ovr = 0;
        out_q.delete();
        last_q.delete();
        cyc_q.delete();
    endtask

    task automatic check_outs_low(input string nm);
        check(nm, 32'({o_data, o_data_valid, o_data_last, o_frame_ok,
                       o_frame_err, o_overrun, o_busy}), 32'd0);
    endtask

    task automatic check_payload(input vec_t v);
        check({v.name, "_nout"}, out_q.size(), v.np);
        for (int i = 0; i < v.np && i < out_q.size(); i++) begin
            check({v.name, "_data"}, 32'(out_q[i]), 32'(v.b[v.pofs + i]));
            check({v.name, "_last"}, 32'(last_q[i]), 32'(i == v.np - 1));
        end
    endtask

    task automatic run_vec(input vec_t v);
        clear_mon();
        ready = 1'b1;
        for (int i = 0; i < v.n; i++) send(v.b[i]);
        tick(24);
        check({v.name, "_ok"}, n_ok, v.ok);
        check({v.name, "_err"}, n_err, v.err);
        check_payload(v);
        if (v.np > 0 && out_q.size() == v.np)
            check({v.name, "_consec"}, cyc_q[v.np-1] - cyc_q[0], v.np - 1);
        check({v.name, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    function automatic vec_t mk(input string nm, input int n,
                                input logic [159:0] raw, input int ok,
                                input int err, input int pofs, input int np);
        vec_t v;
        v.name = nm;
        v.n    = n;
        v.b    = raw << (8 * (20 - n));
        v.ok   = ok;
        v.err  = err;
        v.pofs = pofs;
        v.np   = np;
        return v;
    endfunction

    vec_t tbl[8];
    vec_t good;

    initial begin
        clear_mon();
        good = mk("good", 6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33,
                                   8'h03}), 1, 0, 2, 3);
        tbl[0] = good;
        tbl[1] = mk("badchk", 6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33,
                                       8'h04}), 0, 1, 2, 0);
        tbl[2] = mk("len0", 2, 160'({8'hA5, 8'h00}), 0, 1, 2, 0);
        tbl[3] = mk("len17", 2, 160'({8'hA5, 8'h11}), 0, 1, 2, 0);
        tbl[4] = mk("good2", 6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33,
                                      8'h03}), 1, 0, 2, 3);
        tbl[5] = mk("noise_sof", 6, 160'({8'h00, 8'hFF, 8'hA5, 8'h01,
                                          8'hA5, 8'hA4}), 1, 0, 4, 1);
        tbl[6] = mk("len1", 4, 160'({8'hA5, 8'h01, 8'h7E, 8'h7F}),
                    1, 0, 2, 1);
        tbl[7] = mk("len16", 19, 160'(0), 1, 0, 2, 16);
        tbl[7].b[0] = 8'hA5;
        tbl[7].b[1] = 8'h10;
        for (int i = 0; i < 16; i++) tbl[7].b[2 + i] = 8'(i + 1);
        tbl[7].b[18] = 8'h00;

        resetn = 1'b0;
        tick(3);
        check_outs_low("reset_outs");
        resetn = 1'b1;
        tick(2);

        for (int k = 0; k < 8; k++) run_vec(tbl[k]);

        // backpressure with an overrun byte mid-drain
        clear_mon();
        ready = 1'b0;
        for (int i = 0; i < good.n; i++) send(good.b[i]);
        tick(2);
        send(8'h55);
        for (int i = 0; i < 16; i++) begin
            ready = ~ready;
            tick();
        end
        ready = 1'b1;
        tick(5);
        check("bp_ok", n_ok, 1);
        check("bp_ovr", n_ovr, 1);
        check("bp_err", n_err, 0);
        good.name = "bp";
        check_payload(good);
        good.name = "good";
        check("bp_busy", 32'(o_busy), 32'd0);

        // inter-byte timeout
        clear_mon();
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        tick(95);
        check("to_early_err", n_err, 0);
        check("to_early_busy", 32'(o_busy), 32'd1);
        tick(10);
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        check("to_err", n_err, 1);
        check("to_busy", 32'(o_busy), 32'd0);
`else
        check("to_err", n_err, 0);
        check("to_busy", 32'(o_busy), 32'd1);
`endif
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick(2);

        // reset mid-payload, then a clean frame
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        check("midpay_busy", 32'(o_busy), 32'd1);
        resetn = 1'b0;
        #1;
        check_outs_low("midpay_rst_outs");
        tick(2);
        resetn = 1'b1;
        tick(2);
        good.name = "after_rst";
        run_vec(good);

        // reset mid-drain, then a clean frame
        ready = 1'b0;
        for (int i = 0; i < good.n; i++) send(good.b[i]);
        tick(2);
        check("middrain_valid", 32'(o_data_valid), 32'd1);
        check("middrain_data", 32'(o_data), 32'h11);
        resetn = 1'b0;
        #1;
        check_outs_low("middrain_rst_outs");
        tick(2);
        resetn = 1'b1;
        tick(2);
        good.name = "after_rst2";
        run_vec(good);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
